// File: rtl/wb_select_stage_if.sv
// wb_select_stage_if
//   Bundles the M-stage inputs, pipeline control and W-stage outputs of the
//   write-back select stage.
//   master : pipeline side (drives stall/flush and m_*, observes w_*)
//   slave  : the stage itself (observes stall/flush and m_*, drives w_*)
interface wb_select_stage_if #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
);
    logic             stall;
    logic             flush;
    logic             m_valid;
    logic             m_we;
    logic [RA_W-1:0]  m_wa;
    logic [2:0]       m_wsel;
    logic [2:0]       m_load_type;
    logic [1:0]       m_addr_lo;
    logic [WIDTH-1:0] m_alu;
    logic [WIDTH-1:0] m_rdata;
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_hilo;

    logic             w_valid;
    logic             w_we;
    logic [RA_W-1:0]  w_wa;
    logic [WIDTH-1:0] w_wd;
    logic             w_misalign;
    logic [31:0]      w_retire_cnt;

    modport master (
        output stall, flush, m_valid, m_we, m_wa, m_wsel, m_load_type,
               m_addr_lo, m_alu, m_rdata, m_pc, m_hilo,
        input  w_valid, w_we, w_wa, w_wd, w_misalign, w_retire_cnt
    );

    modport slave (
        input  stall, flush, m_valid, m_we, m_wa, m_wsel, m_load_type,
               m_addr_lo, m_alu, m_rdata, m_pc, m_hilo,
        output w_valid, w_we, w_wa, w_wd, w_misalign, w_retire_cnt
    );
endinterface

// File: rtl/wb_select_stage.sv
// wb_select_stage
//   MEM/WB pipeline register fused with write-back source selection, load
//   byte/half extraction with sign/zero extension, and link-address
//   generation. All outputs are registered; w_wd is fully formed before the
//   flop so downstream forwarding sees a clean register output.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    wb_select_stage_if.slave: stall/flush, M-stage inputs, W outputs
module wb_select_stage #(
    parameter int          WIDTH       = 32,
    parameter int          RA_W        = 5,
    parameter int          LINK_OFFSET = 8,
    parameter logic [31:0] SENTINEL    = 32'h12345678
) (
    input  logic                clk,
    input  logic                reset,
    wb_select_stage_if.slave    bus
);
    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LBU = 3'd1;
    localparam logic [2:0] LT_LB  = 3'd2;
    localparam logic [2:0] LT_LHU = 3'd3;
    localparam logic [2:0] LT_LH  = 3'd4;

    localparam logic [WIDTH-1:0] SENT_W = WIDTH'(SENTINEL);
    localparam logic [WIDTH-1:0] LINK_W = WIDTH'(LINK_OFFSET);

    logic             valid_q;
    logic             we_q;
    logic [RA_W-1:0]  wa_q;
    logic [WIDTH-1:0] wd_q;
    logic             misalign_q;
    logic [31:0]      retire_cnt;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_val;
    logic [WIDTH-1:0] wd_d;
    logic             we_d;
    logic             misalign_d;

    // Byte/half lanes; the half lane ignores addr_lo[0].
    always_comb begin
        ld_byte = 8'h00;
        case (bus.m_addr_lo)
            2'd0:    ld_byte = bus.m_rdata[7:0];
            2'd1:    ld_byte = bus.m_rdata[15:8];
            2'd2:    ld_byte = bus.m_rdata[23:16];
            default: ld_byte = bus.m_rdata[31:24];
        endcase
        ld_half = bus.m_addr_lo[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    end

    // Load types 5-7 fall through to the full-word path.
    always_comb begin
        ld_val = bus.m_rdata;
        case (bus.m_load_type)
            LT_LBU:  ld_val = {{(WIDTH-8){1'b0}}, ld_byte};
            LT_LB:   ld_val = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            LT_LHU:  ld_val = {{(WIDTH-16){1'b0}}, ld_half};
            LT_LH:   ld_val = {{(WIDTH-16){ld_half[15]}}, ld_half};
            default: ld_val = bus.m_rdata;
        endcase
    end

    always_comb begin
        wd_d = SENT_W;
        case (bus.m_wsel)
            3'd0:    wd_d = bus.m_alu;
            3'd1:    wd_d = ld_val;
            3'd2:    wd_d = bus.m_pc + LINK_W;
            3'd3:    wd_d = bus.m_hilo;
            default: wd_d = SENT_W;
        endcase
    end

    // A full-word load is misaligned on any nonzero offset, a half only on
    // an odd one. The word data itself is passed through untouched.
    always_comb begin
        misalign_d = 1'b0;
        if (bus.m_valid && (bus.m_wsel == 3'd1)) begin
            case (bus.m_load_type)
                LT_LW:          misalign_d = (bus.m_addr_lo != 2'd0);
                LT_LHU, LT_LH:  misalign_d = bus.m_addr_lo[0];
                LT_LBU, LT_LB:  misalign_d = 1'b0;
                default:        misalign_d = (bus.m_addr_lo != 2'd0);
            endcase
        end
        we_d = bus.m_valid && bus.m_we && (bus.m_wa != '0);
    end

    // Flush beats stall; the retire counter is untouched by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            misalign_q <= 1'b0;
            retire_cnt <= 32'd0;
        end else if (bus.flush) begin
            valid_q    <= 1'b0;
            we_q       <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
            misalign_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q    <= bus.m_valid;
            we_q       <= we_d;
            wa_q       <= bus.m_wa;
            wd_q       <= wd_d;
            misalign_q <= misalign_d;
            if (bus.m_valid) begin
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    assign bus.w_valid      = valid_q;
    assign bus.w_we         = we_q;
    assign bus.w_wa         = wa_q;
    assign bus.w_wd         = wd_q;
    assign bus.w_misalign   = misalign_q;
    assign bus.w_retire_cnt = retire_cnt;
endmodule

// File: tb/tb_wb_select_stage.sv
module tb_wb_select_stage;
    logic clk;
    logic reset;

    wb_select_stage_if #(.WIDTH(32), .RA_W(5)) bus ();

    wb_select_stage #(
        .WIDTH(32), .RA_W(5), .LINK_OFFSET(8), .SENTINEL(32'h12345678)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_cnt;

    typedef struct {
        string       name;
        logic        v;
        logic        we;
        logic [4:0]  wa;
        logic [2:0]  wsel;
        logic [2:0]  lt;
        logic [1:0]  lo;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc;
        logic [31:0] hilo;
        logic        e_valid;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic v, logic we, logic [4:0] wa,
                                logic [2:0] wsel, logic [2:0] lt, logic [1:0] lo,
                                logic [31:0] alu, logic [31:0] rdata,
                                logic [31:0] pc, logic [31:0] hilo,
                                logic e_valid, logic e_we, logic [4:0] e_wa,
                                logic [31:0] e_wd, logic e_mis);
        vec_t r;
        r.name = name; r.v = v; r.we = we; r.wa = wa; r.wsel = wsel; r.lt = lt;
        r.lo = lo; r.alu = alu; r.rdata = rdata; r.pc = pc; r.hilo = hilo;
        r.e_valid = e_valid; r.e_we = e_we; r.e_wa = e_wa; r.e_wd = e_wd;
        r.e_mis = e_mis;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(string name, logic v, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic mis, logic [31:0] cnt);
        check({name, ".w_valid"}, 64'(bus.w_valid), 64'(v));
        check({name, ".w_we"}, 64'(bus.w_we), 64'(we));
        check({name, ".w_wa"}, 64'(bus.w_wa), 64'(wa));
        check({name, ".w_wd"}, 64'(bus.w_wd), 64'(wd));
        check({name, ".w_misalign"}, 64'(bus.w_misalign), 64'(mis));
        check({name, ".w_retire_cnt"}, 64'(bus.w_retire_cnt), 64'(cnt));
    endtask

    task automatic drive(logic v, logic we, logic [4:0] wa, logic [2:0] wsel,
                         logic [2:0] lt, logic [1:0] lo, logic [31:0] alu,
                         logic [31:0] rdata, logic [31:0] pc, logic [31:0] hilo);
        bus.m_valid = v; bus.m_we = we; bus.m_wa = wa; bus.m_wsel = wsel;
        bus.m_load_type = lt; bus.m_addr_lo = lo; bus.m_alu = alu;
        bus.m_rdata = rdata; bus.m_pc = pc; bus.m_hilo = hilo;
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 3'd0, 3'd0, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        exp_cnt = 32'd0;

        // name, v, we, wa, wsel, lt, lo, alu, rdata, pc, hilo | valid, we, wa, wd, mis
        vecs.push_back(mk("lb_lo2",   1,1,5'd3, 3'd1,3'd2,2'd2, 32'h0,RD,32'h0,32'h0, 1,1,5'd3, 32'hFFFFFFFF,0));
        vecs.push_back(mk("lbu_lo3",  1,1,5'd4, 3'd1,3'd1,2'd3, 32'h0,RD,32'h0,32'h0, 1,1,5'd4, 32'h00000080,0));
        vecs.push_back(mk("lh_lo2",   1,1,5'd5, 3'd1,3'd4,2'd2, 32'h0,RD,32'h0,32'h0, 1,1,5'd5, 32'hFFFF80FF,0));
        vecs.push_back(mk("lhu_lo0",  1,1,5'd6, 3'd1,3'd3,2'd0, 32'h0,RD,32'h0,32'h0, 1,1,5'd6, 32'h00007F01,0));
        vecs.push_back(mk("lh_lo1",   1,1,5'd7, 3'd1,3'd4,2'd1, 32'h0,RD,32'h0,32'h0, 1,1,5'd7, 32'h00007F01,1));
        vecs.push_back(mk("lhu_lo3",  1,1,5'd8, 3'd1,3'd3,2'd3, 32'h0,RD,32'h0,32'h0, 1,1,5'd8, 32'h000080FF,1));
        vecs.push_back(mk("lb_lo1",   1,1,5'd9, 3'd1,3'd2,2'd1, 32'h0,RD,32'h0,32'h0, 1,1,5'd9, 32'h0000007F,0));
        vecs.push_back(mk("lw_lo2",   1,1,5'd10,3'd1,3'd0,2'd2, 32'h0,RD,32'h0,32'h0, 1,1,5'd10,32'h80FF7F01,1));
        vecs.push_back(mk("lt6_lo0",  1,1,5'd11,3'd1,3'd6,2'd0, 32'h0,RD,32'h0,32'h0, 1,1,5'd11,32'h80FF7F01,0));
        vecs.push_back(mk("link",     1,1,5'd31,3'd2,3'd0,2'd0, 32'h0,RD,32'h00003000,32'h0, 1,1,5'd31,32'h00003008,0));
        vecs.push_back(mk("link_wrap",1,1,5'd31,3'd2,3'd0,2'd0, 32'h0,RD,32'hFFFFFFFC,32'h0, 1,1,5'd31,32'h00000004,0));
        vecs.push_back(mk("sel5",     1,1,5'd12,3'd5,3'd0,2'd0, 32'h1,RD,32'h2,32'h3, 1,1,5'd12,32'h12345678,0));
        vecs.push_back(mk("sel7",     1,1,5'd12,3'd7,3'd1,2'd1, 32'h1,RD,32'h2,32'h3, 1,1,5'd12,32'h12345678,0));
        vecs.push_back(mk("reg0",     1,1,5'd0, 3'd0,3'd0,2'd0, 32'h5,RD,32'h0,32'h0, 1,0,5'd0, 32'h00000005,0));
        vecs.push_back(mk("hilo",     1,1,5'd13,3'd3,3'd0,2'd0, 32'h0,RD,32'h0,32'hDEADBEEF, 1,1,5'd13,32'hDEADBEEF,0));
        vecs.push_back(mk("no_we",    1,0,5'd9, 3'd0,3'd0,2'd0, 32'hCAFE0001,RD,32'h0,32'h0, 1,0,5'd9, 32'hCAFE0001,0));
        vecs.push_back(mk("alu_lh_odd",1,1,5'd14,3'd0,3'd4,2'd3, 32'h00000042,RD,32'h0,32'h0, 1,1,5'd14,32'h00000042,0));
        vecs.push_back(mk("invalid",  0,1,5'd15,3'd1,3'd0,2'd1, 32'h0,RD,32'h0,32'h0, 0,0,5'd15,32'h80FF7F01,0));

        #12;
        check_outs("reset", 0, 0, 5'd0, 32'h0, 0, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].v, vecs[i].we, vecs[i].wa, vecs[i].wsel, vecs[i].lt,
                  vecs[i].lo, vecs[i].alu, vecs[i].rdata, vecs[i].pc, vecs[i].hilo);
            @(posedge clk);
            #1;
            if (vecs[i].v) exp_cnt = exp_cnt + 32'd1;
            check_outs(vecs[i].name, vecs[i].e_valid, vecs[i].e_we, vecs[i].e_wa,
                       vecs[i].e_wd, vecs[i].e_mis, exp_cnt);
        end

        // Stall/flush sequence: capture A, hold through two stalls, then
        // stall+flush produces a bubble with the counter unchanged.
        @(negedge clk);
        drive(1, 1, 5'd7, 3'd0, 3'd0, 2'd0, 32'h0000AAAA, RD, 32'h0, 32'h0);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 32'd1;
        check_outs("cap_a", 1, 1, 5'd7, 32'h0000AAAA, 0, exp_cnt);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.stall = 1'b1;
            drive(1, 1, 5'd20 + 5'(k), 3'd2, 3'd0, 2'd1, 32'h0000BBBB, RD,
                  32'h00001000, 32'h0);
            @(posedge clk); #1;
            check_outs("stall_hold", 1, 1, 5'd7, 32'h0000AAAA, 0, exp_cnt);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        check_outs("stall_flush", 0, 0, 5'd0, 32'h0, 0, exp_cnt);
        @(negedge clk);
        bus.stall = 1'b0;
        drive(1, 1, 5'd3, 3'd1, 3'd0, 2'd1, 32'h0, RD, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_outs("flush_only", 0, 0, 5'd0, 32'h0, 0, exp_cnt);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(0, 1, 5'd3, 3'd0, 3'd0, 2'd0, 32'h00000011, RD, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_outs("bubble_cap", 0, 0, 5'd3, 32'h00000011, 0, exp_cnt);

        // Asynchronous reset between edges.
        @(negedge clk);
        drive(1, 1, 5'd4, 3'd3, 3'd0, 2'd0, 32'h0, RD, 32'h0, 32'h55555555);
        @(posedge clk); #1;
        exp_cnt = exp_cnt + 32'd1;
        check_outs("pre_reset", 1, 1, 5'd4, 32'h55555555, 0, exp_cnt);
        #2;
        reset = 1'b1;
        #1;
        exp_cnt = 32'd0;
        check_outs("async_reset", 0, 0, 5'd0, 32'h0, 0, exp_cnt);
        @(negedge clk);
        reset = 1'b0;

        // Counter wrap via backdoor preload.
        @(negedge clk);
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        drive(1, 1, 5'd2, 3'd0, 3'd0, 2'd0, 32'h00000099, RD, 32'h0, 32'h0);
        @(posedge clk); #1;
        check_outs("cnt_wrap", 1, 1, 5'd2, 32'h00000099, 0, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        check("cnt_after_wrap", 64'(bus.w_retire_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
